mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the RV32 pipeline, between execute and writeback. Accepts one instruction at a time from execute and runs loads/stores over a req/ack data bus. Load data is byte-aligned and sign/zero-extended. Each result goes into the M/WB pipeline register that feeds writeback.

## Interface
- No parameters; data width is fixed at 32 (XLEN).
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute presents an instruction this cycle.
- ex_ready  out  1  stage can accept; high only in IDLE.
- ex_aluresult  in  32  ALU result; also the effective address for loads and stores.
- ex_store_data  in  32  rs2 value for stores.
- ex_funct3  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- ex_mem_load, ex_mem_store  in  1  access type; never both high.
- ex_reg_wr  in  1  instruction writes rd.
- ex_reg_wnum  in  5  rd index.
- dmem_req  out  1  bus request; held until ack.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address (low two bits 0).
- dmem_wdata  out  32  store data shifted into its lanes.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read data, valid in the ack cycle.
- dmem_ack  in  1  one-cycle completion pulse.
- mwb_valid  out  1  M/WB register holds a retiring instruction.
- mwb_reg_wr  out  1  rd write enable; forced to 0 when mwb_valid is 0.
- mwb_reg_wnum  out  5  rd index.
- mwb_aluresult  out  32  forwarded ALU result.
- mwb_mem_load  out  1  writeback selects load data.
- mwb_mem_dat_i_w  out  32  aligned, extended load data; 0 for non-loads.
- mem_fault  out  1  one-cycle misaligned-access pulse (see Configuration).

## Operation
- FSM states: IDLE, BUS.
- IDLE with ex_valid and no memory op: capture into M/WB. State stays IDLE.
- IDLE with ex_valid and load/store: latch address, size, data and control, then go to BUS.
  - dmem_req rises the next cycle.
  - dmem_addr, dmem_we, dmem_be and dmem_wdata stay stable while dmem_req is high.
- BUS: hold dmem_req until dmem_ack.
  - In the ack cycle, dmem_req drops, the M/WB register is loaded and the FSM returns to IDLE.
  - For a load, the extended dmem_rdata goes into mwb_mem_dat_i_w.
- Byte lane = addr[1:0].
  - Byte ops: be = 0001 << lane.
  - Half ops: be = 0011 << lane.
  - Word ops: be = 1111.
  - wdata = store_data << 8*lane, with byte and half data replicated from the low bits.
- Load extract: the selected byte or half is shifted to bit 0, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- mwb_valid pulses for exactly one cycle per retired instruction. On bubble cycles all mwb_* outputs are 0.
- dmem_ack outside BUS is ignored.

## Timing
- Reset values: state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata = 0; all mwb_* = 0; mem_fault = 0; ex_ready = 1 once reset is released.
- Reset during BUS drops dmem_req in the next cycle. A late ack for that access is discarded.
- Non-memory latency: accept in cycle N, mwb_valid in cycle N+1.
- Memory latency: accept in cycle N, dmem_req high from N+1. Ack in cycle K gives mwb_valid in cycle K+1.
- Zero-wait bus: ack in N+1 gives mwb_valid in N+2.
- ex_ready is low from N+1 through K. The stage accepts again in cycle K+1.
- No backpressure from writeback; it consumes every cycle.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned cases: a half access with addr[0]=1, or a word access with addr[1:0]≠00.
  - Such an access does not enter BUS and never asserts dmem_req.
  - mem_fault pulses in cycle N+1 with mwb_valid=1 and mwb_reg_wr=0.
- Undefined:
  - mem_fault is tied to 0.
  - Misaligned addresses are truncated to the access size and issued normally: half ignores addr[0], word ignores addr[1:0].

## Test plan
- ADD result 0x1234, rd=5, reg_wr=1 → next cycle: mwb_valid=1, mwb_reg_wnum=5, mwb_aluresult=0x1234, mwb_mem_dat_i_w=0.
- LB at addr 0x103, rdata 0x80FFFFFF, ack after 3 wait cycles → dmem_addr=0x100, be=1000, mwb_mem_dat_i_w=0xFFFFFF80; ex_ready low throughout.
- LHU at addr 0x102, rdata 0xBEEF0000, zero-wait → mwb_mem_dat_i_w=0x0000BEEF, mwb_valid two cycles after accept.
- SB data 0xAB at addr 0x201 → dmem_we=1, be=0010, wdata=0xABABABAB, mwb_reg_wr=0.
- rst asserted while in BUS awaiting ack → dmem_req=0 next cycle, FSM in IDLE, late ack produces no mwb_valid.
- With MEM_MISALIGN_TRAP_EN: LW at 0x102 → no dmem_req, mem_fault=1 one cycle, mwb_reg_wr=0.

Source files
------------

// File: rtl/mem_access.sv
// RV32 memory-access stage: req/ack data bus, lane steering, load extension, M/WB register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being truncated.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_aluresult,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_mem_load,
  input  logic        ex_mem_store,
  input  logic        ex_reg_wr,
  input  logic [4:0]  ex_reg_wnum,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mwb_valid,
  output logic        mwb_reg_wr,
  output logic [4:0]  mwb_reg_wnum,
  output logic [31:0] mwb_aluresult,
  output logic        mwb_mem_load,
  output logic [31:0] mwb_mem_dat_i_w,
  output logic        mem_fault
);

  typedef enum logic [0:0] {IDLE, BUS} state_t;

  state_t      state, state_next;
  logic        accept, mem_op, ack_hit, misalign;
  logic [1:0]  size_in, lane_in, lane_q;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, rdata_sh, load_ext;
  logic [2:0]  funct3_q;
  logic        load_q, reg_wr_q;
  logic [4:0]  wnum_q;
  logic [31:0] alu_q;

  assign ex_ready = (state == IDLE);
  assign dmem_req = (state == BUS);
  assign accept   = ex_valid && (state == IDLE);
  assign mem_op   = ex_mem_load || ex_mem_store;
  assign ack_hit  = (state == BUS) && dmem_ack;
  assign size_in  = ex_funct3[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = ((size_in == 2'b01) && ex_aluresult[0]) ||
                    (size_in[1] && (ex_aluresult[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane is truncated to the access size, so misaligned halves/words fold onto aligned lanes.
  always_comb begin
    lane_in  = 2'b00;
    be_in    = 4'b1111;
    wdata_in = ex_store_data;
    case (size_in)
      2'b00: begin
        lane_in  = ex_aluresult[1:0];
        be_in    = 4'b0001 << ex_aluresult[1:0];
        wdata_in = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        lane_in  = {ex_aluresult[1], 1'b0};
        be_in    = 4'b0011 << {ex_aluresult[1], 1'b0};
        wdata_in = {2{ex_store_data[15:0]}};
      end
      default: begin
        lane_in  = 2'b00;
        be_in    = 4'b1111;
        wdata_in = ex_store_data;
      end
    endcase
  end

  always_comb begin
    rdata_sh = dmem_rdata >> {lane_q, 3'b000};
    load_ext = rdata_sh;
    case (funct3_q[1:0])
      2'b00:   load_ext = funct3_q[2] ? {24'h0, rdata_sh[7:0]}
                                      : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      2'b01:   load_ext = funct3_q[2] ? {16'h0, rdata_sh[15:0]}
                                      : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      default: load_ext = rdata_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && mem_op && !misalign) state_next = BUS;
      BUS:     if (dmem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_we         <= 1'b0;
      dmem_addr       <= 32'h0;
      dmem_wdata      <= 32'h0;
      dmem_be         <= 4'h0;
      lane_q          <= 2'b00;
      funct3_q        <= 3'b000;
      load_q          <= 1'b0;
      reg_wr_q        <= 1'b0;
      wnum_q          <= 5'd0;
      alu_q           <= 32'h0;
      mwb_valid       <= 1'b0;
      mwb_reg_wr      <= 1'b0;
      mwb_reg_wnum    <= 5'd0;
      mwb_aluresult   <= 32'h0;
      mwb_mem_load    <= 1'b0;
      mwb_mem_dat_i_w <= 32'h0;
    end else begin
      // M/WB is a one-cycle pulse: everything returns to zero on bubble cycles.
      mwb_valid       <= 1'b0;
      mwb_reg_wr      <= 1'b0;
      mwb_reg_wnum    <= 5'd0;
      mwb_aluresult   <= 32'h0;
      mwb_mem_load    <= 1'b0;
      mwb_mem_dat_i_w <= 32'h0;
      if (accept) begin
        if (!mem_op || misalign) begin
          mwb_valid     <= 1'b1;
          mwb_reg_wr    <= ex_reg_wr && !misalign;
          mwb_reg_wnum  <= ex_reg_wnum;
          mwb_aluresult <= ex_aluresult;
        end else begin
          dmem_we    <= ex_mem_store;
          dmem_addr  <= {ex_aluresult[31:2], 2'b00};
          dmem_wdata <= wdata_in;
          dmem_be    <= be_in;
          lane_q     <= lane_in;
          funct3_q   <= ex_funct3;
          load_q     <= ex_mem_load;
          reg_wr_q   <= ex_reg_wr;
          wnum_q     <= ex_reg_wnum;
          alu_q      <= ex_aluresult;
        end
      end
      if (ack_hit) begin
        mwb_valid       <= 1'b1;
        mwb_reg_wr      <= reg_wr_q;
        mwb_reg_wnum    <= wnum_q;
        mwb_aluresult   <= alu_q;
        mwb_mem_load    <= load_q;
        mwb_mem_dat_i_w <= load_q ? load_ext : 32'h0;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) mem_fault <= 1'b0;
    else     mem_fault <= accept && mem_op && misalign;
  end
`else
  assign mem_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: vector table plus scoreboard on the M/WB outputs.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_aluresult, ex_store_data;
  logic [2:0]  ex_funct3;
  logic        ex_mem_load, ex_mem_store, ex_reg_wr;
  logic [4:0]  ex_reg_wnum;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        mwb_valid, mwb_reg_wr, mwb_mem_load, mem_fault;
  logic [4:0]  mwb_reg_wnum;
  logic [31:0] mwb_aluresult, mwb_mem_dat_i_w;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluresult(ex_aluresult), .ex_store_data(ex_store_data),
    .ex_funct3(ex_funct3), .ex_mem_load(ex_mem_load), .ex_mem_store(ex_mem_store),
    .ex_reg_wr(ex_reg_wr), .ex_reg_wnum(ex_reg_wnum),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mwb_valid(mwb_valid), .mwb_reg_wr(mwb_reg_wr), .mwb_reg_wnum(mwb_reg_wnum),
    .mwb_aluresult(mwb_aluresult), .mwb_mem_load(mwb_mem_load),
    .mwb_mem_dat_i_w(mwb_mem_dat_i_w), .mem_fault(mem_fault)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [2:0]  f3;
    logic        ld;
    logic        st;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          waits;
    logic        fault;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_dat;
  } vec_t;

  typedef struct {
    logic        reg_wr;
    logic [4:0]  wnum;
    logic [31:0] alu;
    logic        mem_load;
    logic [31:0] dat;
    logic        fault;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  exp_t sbq[$];
  exp_t mon_e;
  vec_t tv[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every retirement must match the oldest pushed expectation; bubbles must be all-zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mwb_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_mwb_valid", {31'b0, mwb_valid}, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("mwb_reg_wr", {31'b0, mwb_reg_wr}, {31'b0, mon_e.reg_wr});
          chk("mem_fault", {31'b0, mem_fault}, {31'b0, mon_e.fault});
          if (!mon_e.fault) begin
            chk("mwb_reg_wnum", {27'b0, mwb_reg_wnum}, {27'b0, mon_e.wnum});
            chk("mwb_aluresult", mwb_aluresult, mon_e.alu);
            chk("mwb_mem_load", {31'b0, mwb_mem_load}, {31'b0, mon_e.mem_load});
            chk("mwb_mem_dat_i_w", mwb_mem_dat_i_w, mon_e.dat);
          end
        end
      end else begin
        chk("bubble_zero",
            {30'b0, mwb_reg_wr | mwb_mem_load | (|mwb_reg_wnum) | (|mwb_aluresult) | (|mwb_mem_dat_i_w),
             mem_fault}, 32'd0);
      end
    end
  end

  task automatic clear_ex();
    ex_valid = 1'b0; ex_mem_load = 1'b0; ex_mem_store = 1'b0; ex_reg_wr = 1'b0;
    ex_aluresult = 32'h0; ex_store_data = 32'h0; ex_funct3 = 3'b000; ex_reg_wnum = 5'd0;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.reg_wr   = v.fault ? 1'b0 : v.rw;
    e.wnum     = v.rd;
    e.alu      = v.alu;
    e.mem_load = v.ld && !v.fault;
    e.dat      = (v.ld && !v.fault) ? v.e_dat : 32'h0;
    e.fault    = v.fault;
    sbq.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    chk("ex_ready_before_accept", {31'b0, ex_ready}, 32'd1);
    ex_valid = 1'b1; ex_aluresult = v.alu; ex_store_data = v.sd; ex_funct3 = v.f3;
    ex_mem_load = v.ld; ex_mem_store = v.st; ex_reg_wr = v.rw; ex_reg_wnum = v.rd;
    push_exp(v);
    @(posedge clk); #1;
    clear_ex();
    if ((!v.ld && !v.st) || v.fault) begin
      chk("latency1_mwb_valid", {31'b0, mwb_valid}, 32'd1);
      chk("no_req_direct", {31'b0, dmem_req}, 32'd0);
      for (int i = 0; i < 2; i++) begin
        @(posedge clk); #1;
        chk("no_req_after_direct", {31'b0, dmem_req}, 32'd0);
        chk("ready_after_direct", {31'b0, ex_ready}, 32'd1);
      end
    end else begin
      chk("dmem_req_rise", {31'b0, dmem_req}, 32'd1);
      chk("ex_ready_low", {31'b0, ex_ready}, 32'd0);
      chk("dmem_addr", dmem_addr, v.e_addr);
      chk("dmem_be", {28'b0, dmem_be}, {28'b0, v.e_be});
      chk("dmem_we", {31'b0, dmem_we}, {31'b0, v.st});
      if (v.st) chk("dmem_wdata", dmem_wdata, v.e_wdata);
      for (int i = 0; i < v.waits; i++) begin
        @(posedge clk); #1;
        chk("req_held", {31'b0, dmem_req}, 32'd1);
        chk("ready_low_wait", {31'b0, ex_ready}, 32'd0);
        chk("addr_stable", dmem_addr, v.e_addr);
        chk("be_stable", {28'b0, dmem_be}, {28'b0, v.e_be});
      end
      dmem_rdata = v.rdata; dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      chk("ack_mwb_valid", {31'b0, mwb_valid}, 32'd1);
      chk("req_drop_after_ack", {31'b0, dmem_req}, 32'd0);
      chk("ready_after_ack", {31'b0, ex_ready}, 32'd1);
    end
  endtask

  initial begin
    //          alu           sd            f3      ld    st    rw    rd     rdata         w  flt   e_addr        e_be     e_wdata       e_dat
    tv[0]  = '{32'h0000_1234, 32'h0,        3'b000, 1'b0, 1'b0, 1'b1, 5'd5,  32'h0,        0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0};
    tv[1]  = '{32'h0000_0103, 32'h0,        3'b000, 1'b1, 1'b0, 1'b1, 5'd7,  32'h80FF_FFFF, 3, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80};
    tv[2]  = '{32'h0000_0102, 32'h0,        3'b101, 1'b1, 1'b0, 1'b1, 5'd8,  32'hBEEF_0000, 0, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,        32'h0000_BEEF};
    tv[3]  = '{32'h0000_0201, 32'h0000_00AB, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1, 1'b0, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB, 32'h0};
    tv[4]  = '{32'h0000_0300, 32'h0,        3'b010, 1'b1, 1'b0, 1'b1, 5'd9,  32'hDEAD_BEEF, 2, 1'b0, 32'h0000_0300, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    tv[5]  = '{32'h0000_0402, 32'h0,        3'b001, 1'b1, 1'b0, 1'b1, 5'd10, 32'h8001_0000, 1, 1'b0, 32'h0000_0400, 4'b1100, 32'h0,        32'hFFFF_8001};
    tv[6]  = '{32'h0000_0502, 32'h1234_CAFE, 3'b001, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        0, 1'b0, 32'h0000_0500, 4'b1100, 32'hCAFE_CAFE, 32'h0};
    tv[7]  = '{32'h0000_0600, 32'h0102_0304, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        2, 1'b0, 32'h0000_0600, 4'b1111, 32'h0102_0304, 32'h0};
    tv[8]  = '{32'h0000_0701, 32'h0,        3'b100, 1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_F000, 0, 1'b0, 32'h0000_0700, 4'b0010, 32'h0,        32'h0000_00F0};
    tv[9]  = '{32'hFFFF_FFFF, 32'h0,        3'b000, 1'b0, 1'b0, 1'b0, 5'd31, 32'h0,        0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0};
    tv[10] = '{32'h0000_0800, 32'h0,        3'b000, 1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_007F, 1, 1'b0, 32'h0000_0800, 4'b0001, 32'h0,        32'h0000_007F};
`ifdef MEM_MISALIGN_TRAP_EN
    tv[11] = '{32'h0000_0103, 32'h0,        3'b001, 1'b1, 1'b0, 1'b1, 5'd13, 32'h8000_0000, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
    tv[12] = '{32'h0000_0102, 32'h0,        3'b010, 1'b1, 1'b0, 1'b1, 5'd14, 32'h1234_5678, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
`else
    tv[11] = '{32'h0000_0103, 32'h0,        3'b001, 1'b1, 1'b0, 1'b1, 5'd13, 32'h8000_0000, 1, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF_8000};
    tv[12] = '{32'h0000_0902, 32'h0,        3'b010, 1'b1, 1'b0, 1'b1, 5'd14, 32'h1234_5678, 0, 1'b0, 32'h0000_0900, 4'b1111, 32'h0,        32'h1234_5678};
`endif

    clear_ex();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_dmem_wdata", dmem_wdata, 32'h0);
    chk("rst_dmem_be", {28'b0, dmem_be}, 32'd0);
    chk("rst_mwb_valid", {31'b0, mwb_valid}, 32'd0);
    chk("rst_mem_fault", {31'b0, mem_fault}, 32'd0);
    chk("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
    mon_en = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(tv[i]);

    // Back-to-back non-memory ops retire on consecutive cycles.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_aluresult = 32'h0000_AAAA; ex_reg_wr = 1'b1; ex_reg_wnum = 5'd1;
    sbq.push_back('{1'b1, 5'd1, 32'h0000_AAAA, 1'b0, 32'h0, 1'b0});
    @(posedge clk); #1;
    chk("b2b_first_valid", {31'b0, mwb_valid}, 32'd1);
    chk("b2b_ready", {31'b0, ex_ready}, 32'd1);
    ex_aluresult = 32'h0000_5555; ex_reg_wnum = 5'd2;
    sbq.push_back('{1'b1, 5'd2, 32'h0000_5555, 1'b0, 32'h0, 1'b0});
    @(posedge clk); #1;
    clear_ex();
    chk("b2b_second_valid", {31'b0, mwb_valid}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_pulse_ends", {31'b0, mwb_valid}, 32'd0);

    // A stray ack while idle must do nothing.
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("stray_ack_no_valid", {31'b0, mwb_valid}, 32'd0);
    chk("stray_ack_no_req", {31'b0, dmem_req}, 32'd0);
    chk("stray_ack_ready", {31'b0, ex_ready}, 32'd1);

    // Reset while waiting for ack, then a late ack.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_aluresult = 32'h0000_0A00; ex_funct3 = 3'b010;
    ex_mem_load = 1'b1; ex_reg_wr = 1'b1; ex_reg_wnum = 5'd3;
    @(posedge clk); #1;
    clear_ex();
    chk("rstbus_req_high", {31'b0, dmem_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstbus_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("rstbus_idle", {31'b0, ex_ready}, 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack_no_valid", {31'b0, mwb_valid}, 32'd0);
    chk("late_ack_no_req", {31'b0, dmem_req}, 32'd0);

    run_vec(tv[1]);
    run_vec(tv[0]);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
